// File: rtl/debounce.sv
// Single-bit debouncer: a level change reaches clean_out only after COUNT_MAX consecutive mismatching samples.
// Define DEBOUNCE_SYNC_EN to insert a 2-FF synchronizer ahead of the qualification counter.
module debounce #(
   parameter int COUNT_MAX = 1000,
   parameter int CNT_W     = $clog2(COUNT_MAX + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic noisy_in,
   output logic clean_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT_MAX - 1);

   logic             s;
   logic [CNT_W-1:0] cnt;

`ifdef DEBOUNCE_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (reset) sync_q <= 2'b00;
      else       sync_q <= {sync_q[0], noisy_in};
   end

   assign s = sync_q[1];
`else
   assign s = noisy_in;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         clean_out  <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         if (s == clean_out) begin
            // Any sample back at the current level restarts qualification.
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt        <= '0;
            clean_out  <= s;
            rise_pulse <= s;
            fall_pulse <= ~s;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign busy = (cnt != '0);

endmodule

// File: tb/tb_debounce.sv
// Randomized bench for debounce: a sample-window reference model checks every cycle, plus
// directed latency, glitch, mid-qualification reset and default-parameter scenarios.
module tb_debounce;

   localparam int CM = 8;
`ifdef DEBOUNCE_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif
   localparam int LAT  = CM - 1 + SYNC;
   localparam int LAT2 = 1000 - 1 + SYNC;

   logic clk = 1'b0;
   logic reset = 1'b1, noisy_in = 1'b0;
   logic clean_out, rise_pulse, fall_pulse, busy;
   logic reset2 = 1'b1, noisy2 = 1'b0;
   logic clean2, rise2, fall2, busy2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   debounce #(.COUNT_MAX(CM)) dut (
      .clk(clk), .reset(reset), .noisy_in(noisy_in),
      .clean_out(clean_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .busy(busy)
   );

   debounce dut2 (
      .clk(clk), .reset(reset2), .noisy_in(noisy2),
      .clean_out(clean2), .rise_pulse(rise2), .fall_pulse(fall2), .busy(busy2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // Reference model: s is the input delayed by the synchronizer depth; clean_out flips once
   // the last CM samples since reset all disagree with it.
   bit sdly[$];
   bit win[$];
   bit m_clean, m_rise, m_fall, m_busy;

   task automatic model(input bit nin, input bit rst);
      bit s;
      int diff;
      m_rise = 0;
      m_fall = 0;
      if (rst) begin
         sdly.delete();
         for (int i = 0; i < SYNC; i++) sdly.push_back(1'b0);
         win.delete();
         m_clean = 0;
         m_busy  = 0;
      end else begin
         if (SYNC == 0) s = nin;
         else begin
            s = sdly.pop_front();
            sdly.push_back(nin);
         end
         win.push_back(s);
         if (win.size() > CM) void'(win.pop_front());
         diff = 0;
         foreach (win[i]) if (win[i] != m_clean) diff++;
         if (win.size() == CM && diff == CM) begin
            m_clean = s;
            m_rise  = s;
            m_fall  = !s;
         end
         m_busy = (s != m_clean);
      end
   endtask

   task automatic step(input bit nin, input bit rst, input bit n2 = 1'b0, input bit r2 = 1'b0);
      @(negedge clk);
      noisy_in = nin;
      reset    = rst;
      noisy2   = n2;
      reset2   = r2;
      @(posedge clk);
      model(nin, rst);
      #1;
      chk("clean", clean_out, m_clean);
      chk("rise",  rise_pulse, m_rise);
      chk("fall",  fall_pulse, m_fall);
      chk("busy",  busy, m_busy);
      checks++;
      if (rise_pulse && fall_pulse) begin
         errors++;
         $display("FAIL both_pulses at %0t: got 1 expected 0", $time);
      end
   endtask

   initial begin
      int first, npulse, lvl, len;
      bit busy_seen;

      // Reset held with input high: everything stays 0.
      repeat (2) begin
         step(1, 1, 0, 1);
         chk("rst_clean", clean_out, 0);
         chk("rst_busy", busy, 0);
      end

      // Glitch rejection: 3 high, 4 low, 7 high, then low.
      busy_seen = 0;
      npulse = 0;
      for (int i = 0; i < 30; i++) begin
         step((i < 3) || (i >= 7 && i < 14), 0, 0, 1);
         if (busy) busy_seen = 1;
         npulse += int'(rise_pulse) + int'(fall_pulse);
      end
      chk("glitch_busy_seen", busy_seen, 1);
      chk("glitch_pulses", npulse, 0);
      chk("glitch_clean", clean_out, 0);
      chk("glitch_busy_end", busy, 0);

      // Clean rise: edge index of the change counted from the first edge sampling the new level.
      first = -1; npulse = 0;
      for (int i = 0; i < 30; i++) begin
         step(1, 0, 0, 1);
         if (clean_out && first < 0) first = i;
         npulse += int'(rise_pulse);
      end
      chk("rise_latency", first, LAT);
      chk("rise_pulse_count", npulse, 1);

      // Clean fall.
      first = -1; npulse = 0;
      for (int i = 0; i < 30; i++) begin
         step(0, 0, 0, 1);
         if (!clean_out && first < 0) first = i;
         npulse += int'(fall_pulse);
      end
      chk("fall_latency", first, LAT);
      chk("fall_pulse_count", npulse, 1);

      // Reset mid-qualification once the counter has reached 5.
      repeat (SYNC + 5) step(1, 0, 0, 1);
      chk("midq_busy", busy, 1);
      step(1, 1, 0, 1);
      chk("midq_rst_busy", busy, 0);
      first = -1; npulse = 0;
      for (int i = 0; i < 30; i++) begin
         step(1, 0, 0, 1);
         if (clean_out && first < 0) first = i;
         npulse += int'(rise_pulse);
      end
      chk("midq_latency", first, LAT);
      chk("midq_pulse_count", npulse, 1);

      // Randomized runs of random length with occasional resets.
      for (int r = 0; r < 120; r++) begin
         lvl = int'($urandom_range(0, 1));
         len = int'($urandom_range(1, 12));
         for (int i = 0; i < len; i++) step(lvl[0], ($urandom_range(0, 59) == 0), 0, 1);
      end

      // Default parameters: 30 ns high, 40 ns low, then held high.
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      first = -1; npulse = 0;
      for (int i = 0; i < 7; i++) begin
         step(0, 0, (i < 3), 0);
         npulse += int'(rise2) + int'(fall2);
      end
      chk("dflt_glitch_pulses", npulse, 0);
      chk("dflt_glitch_clean", clean2, 0);
      for (int i = 0; i < 10000; i++) begin
         step(0, 0, 1, 0);
         if (clean2 && first < 0) first = i;
         npulse += int'(rise2);
      end
      chk("dflt_latency", first, LAT2);
      chk("dflt_rise_count", npulse, 1);
      chk("dflt_clean_end", clean2, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
